// File: rtl/fib_bin2bcd_if.sv
// Handshake bundle between a binary producer (e.g. the Fibonacci FSMD) and
// the double-dabble converter: start/bin in, ready/done_tick/bcd out.
interface fib_bin2bcd_if #(
  parameter int W      = 20,
  parameter int DIGITS = 7
);
  logic                  start;
  logic [W-1:0]          bin;
  logic                  ready;
  logic                  done_tick;
  logic [4*DIGITS-1:0]   bcd;

  modport master (output start, bin, input ready, done_tick, bcd);
  modport slave  (input start, bin, output ready, done_tick, bcd);
endinterface

// File: rtl/fib_bin2bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3), one input bit per
// cycle; start/ready/done_tick match the Fibonacci FSMD so they chain directly.
module fib_bin2bcd #(
  parameter int W      = 20,
  parameter int DIGITS = 7
) (
  input  logic          clk,
  input  logic          reset,
  fib_bin2bcd_if.slave  bus
);
  localparam int NW = $clog2(W + 1);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    OP   = 2'b01,
    DONE = 2'b10
  } state_t;

  state_t                state_q, state_d;
  logic [W-1:0]          bin_q, bin_d;
  logic [4*DIGITS-1:0]   bcd_q, bcd_d;
  logic [NW-1:0]         n_q, n_d;
  logic [4*DIGITS-1:0]   adj;

  // Add 3 to every digit that would reach 10 or more after the next doubling.
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_adj
    assign adj[4*gi +: 4] = (bcd_q[4*gi +: 4] >= 4'd5) ? bcd_q[4*gi +: 4] + 4'd3
                                                       : bcd_q[4*gi +: 4];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      bin_q   <= '0;
      bcd_q   <= '0;
      n_q     <= '0;
    end else begin
      state_q <= state_d;
      bin_q   <= bin_d;
      bcd_q   <= bcd_d;
      n_q     <= n_d;
    end
  end

  always_comb begin
    state_d       = state_q;
    bin_d         = bin_q;
    bcd_d         = bcd_q;
    n_d           = n_q;
    bus.ready     = 1'b0;
    bus.done_tick = 1'b0;
    unique case (state_q)
      IDLE: begin
        bus.ready = 1'b1;
        if (bus.start) begin
          bin_d   = bus.bin;
          bcd_d   = '0;
          n_d     = NW'(W);
          state_d = OP;
        end
      end
      OP: begin
        // The bit falling off the top of adj is always zero for a legal DIGITS.
        bcd_d = (4*DIGITS)'({adj, bin_q[W-1]});
        bin_d = {bin_q[W-2:0], 1'b0};
        n_d   = n_q - NW'(1);
        if (n_q == NW'(1)) state_d = DONE;
      end
      DONE: begin
        bus.done_tick = 1'b1;
        state_d       = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.bcd = bcd_q;
endmodule

// File: tb/tb_fib_bin2bcd.sv
// Self-checking bench for fib_bin2bcd: vector table, Fibonacci chain and
// hand-written corner sequences, with a done_tick-driven scoreboard.
module tb_fib_bin2bcd;
  localparam int W = 20;
  localparam int DIGITS = 7;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  fib_bin2bcd_if #(.W(W), .DIGITS(DIGITS)) bus ();

  fib_bin2bcd #(.W(W), .DIGITS(DIGITS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [19:0] bin;
    logic [27:0] bcd;
  } vec_t;

  vec_t        vecs [8];
  logic [27:0] sb [$];
  int          n_cmp = 0;
  int          n_err = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  int          dt_count = 0;
  logic        prev_done = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [27:0] to_bcd(input int unsigned v);
    logic [27:0] r;
    int unsigned x;
    x = v;
    for (int k = 0; k < 7; k++) begin
      r[4*k +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  // Monitor: every done_tick pops one expected result.
  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (reset) begin
        prev_done = 1'b0;
      end else begin
        if (prev_done) begin
          check("ready_after_done", {31'b0, bus.ready}, 32'd1);
          check("single_done_tick", {31'b0, bus.done_tick}, 32'd0);
        end
        prev_done = bus.done_tick;
        if (bus.done_tick) begin
          dt_count++;
          check("ready_in_done", {31'b0, bus.ready}, 32'd0);
          if (sb.size() == 0) begin
            check("spurious_done", {31'b0, bus.done_tick}, 32'd0);
          end else begin
            check("bcd_result", {4'b0, bus.bcd}, {4'b0, sb.pop_front()});
            check("latency", cyc - start_cyc, 32'd21);
          end
        end
      end
    end
  end

  task automatic start_conv(input logic [19:0] b);
    for (int k = 0; k < 50 && !bus.ready; k++) @(negedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = b;
    @(posedge clk);
    start_cyc = cyc;
    #1;
    bus.start = 1'b0;
    bus.bin   = 20'($urandom);
    @(negedge clk);
    check("ready_low_in_op", {31'b0, bus.ready}, 32'd0);
  endtask

  task automatic convert(input logic [19:0] b, input logic [27:0] exp);
    sb.push_back(exp);
    start_conv(b);
    for (int k = 0; k < 40 && sb.size() != 0; k++) @(negedge clk);
    if (sb.size() != 0) begin
      check("timeout", sb.size(), 32'd0);
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    int dt0;
    int unsigned fa, fb, ft;

    vecs[0] = '{20'd0,       28'h0000000};
    vecs[1] = '{20'd6765,    28'h0006765};
    vecs[2] = '{20'd1048575, 28'h1048575};
    vecs[3] = '{20'd999999,  28'h0999999};
    vecs[4] = '{20'd1,       28'h0000001};
    vecs[5] = '{20'd9,       28'h0000009};
    vecs[6] = '{20'd10,      28'h0000010};
    vecs[7] = '{20'd524288,  28'h0524288};

    bus.start = 1'b0;
    bus.bin   = '0;
    #23 reset = 1'b0;

    // Idle after reset, start low, for 10 cycles.
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      check("idle_ready", {31'b0, bus.ready}, 32'd1);
      check("idle_done", {31'b0, bus.done_tick}, 32'd0);
      check("idle_bcd", {4'b0, bus.bcd}, 32'd0);
    end

    for (int i = 0; i < 8; i++) convert(vecs[i].bin, vecs[i].bcd);

    // Start re-pulsed mid-op and in the done cycle: both ignored.
    dt0 = dt_count;
    sb.push_back(28'h0004181);
    start_conv(20'd4181);
    repeat (7) @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 20'd5;
    @(posedge clk);
    #1 bus.start = 1'b0;
    for (int k = 0; k < 40 && !bus.done_tick; k++) @(negedge clk);
    bus.start = 1'b1;
    bus.bin   = 20'd5;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (30) @(negedge clk);
    check("repulse_done_count", dt_count - dt0, 32'd1);
    check("repulse_bcd_held", {4'b0, bus.bcd}, 32'h0004181);
    if (sb.size() != 0) begin
      check("repulse_pending", sb.size(), 32'd0);
      sb.delete();
    end

    // Reset asserted in op cycle 10: immediate idle, result discarded.
    dt0 = dt_count;
    start_conv(20'd832040);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("rst_ready", {31'b0, bus.ready}, 32'd1);
    check("rst_bcd", {4'b0, bus.bcd}, 32'd0);
    check("rst_done", {31'b0, bus.done_tick}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    repeat (30) @(negedge clk);
    check("rst_no_done", dt_count - dt0, 32'd0);
    convert(20'd832040, 28'h0832040);

    // Fibonacci chain i = 0..29, expected digits derived by decimal division.
    fa = 0;
    fb = 1;
    for (int i = 0; i < 30; i++) begin
      convert(20'(fa), to_bcd(fa));
      ft = fa + fb;
      fa = fb;
      fb = ft;
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end
endmodule
